// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block and the display driver:
// state encoding, BCD digit limits, disp_bcd packing and BCD time helpers.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } state_t;

   // Largest value a units digit and a tens digit may hold in MM:SS.
   localparam logic [3:0] ONES_MAX = 4'd9;
   localparam logic [3:0] TENS_MAX = 4'd5;

   // Packing of disp_bcd, shared with the scan/decode block.
   localparam int DIGIT_W      = 4;
   localparam int SEC_ONES_LSB = 0;
   localparam int SEC_TENS_LSB = 4;
   localparam int MIN_ONES_LSB = 8;
   localparam int MIN_TENS_LSB = 12;

   typedef struct packed {
      logic [3:0] minTens;
      logic [3:0] minOnes;
      logic [3:0] secTens;
      logic [3:0] secOnes;
   } bcd_time_t;

   localparam bcd_time_t TIME_ZERO = '0;
   localparam bcd_time_t TIME_MAX  = '{minTens: TENS_MAX, minOnes: ONES_MAX,
                                       secTens: TENS_MAX, secOnes: ONES_MAX};

   // Advance a MM:SS value by one second, rippling carries digit by digit
   // and rolling 59:59 over to 00:00.
   function automatic bcd_time_t bcdIncrement(input bcd_time_t t);
      bcd_time_t n;
      n = t;
      if (t.secOnes != ONES_MAX) begin
         n.secOnes = t.secOnes + 4'd1;
      end else begin
         n.secOnes = 4'd0;
         if (t.secTens != TENS_MAX) begin
            n.secTens = t.secTens + 4'd1;
         end else begin
            n.secTens = 4'd0;
            if (t.minOnes != ONES_MAX) begin
               n.minOnes = t.minOnes + 4'd1;
            end else begin
               n.minOnes = 4'd0;
               n.minTens = (t.minTens != TENS_MAX) ? t.minTens + 4'd1 : 4'd0;
            end
         end
      end
      return n;
   endfunction

   // True when the next increment is the 59:59 -> 00:00 rollover.
   function automatic logic bcdIsMax(input bcd_time_t t);
      return (t == TIME_MAX);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press pulse on each accepted 0->1 change of the debounced level.
module btn_debounce #(
   parameter int DEB_CYCLES = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] STABLE_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] stable_q;
   logic          level_q;
   logic          press_q;

   // Bring the asynchronous pad level into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed for DEB_CYCLES cycles in a
   // row; any return to the old level restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q <= '0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         press_q <= 1'b0;
         if (sync2_q != level_q) begin
            if (stable_q == STABLE_LAST) begin
               level_q  <= sync2_q;
               stable_q <= '0;
               press_q  <= sync2_q;
            end else begin
               stable_q <= stable_q + CW'(1);
            end
         end else begin
            stable_q <= '0;
         end
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, IDLE/RUN/PAUSE/LAP state machine,
// 1 Hz prescaler, BCD MM:SS counter, lap register and registered display mux.
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int FREQ       = 2000,
   parameter int DEB_CYCLES = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_ss,
   input  logic        btn_lap,
   input  logic        btn_clr,
   output logic [15:0] disp_bcd,
   output logic        running,
   output logic        frozen,
   output logic [1:0]  state,
   output logic        wrap
);

   localparam int PW = (FREQ > 1) ? $clog2(FREQ) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(FREQ - 1);

   logic          pressSs;
   logic          pressLap;
   logic          pressClr;
   logic [2:0]    unusedLevel;

   state_t        state_q;
   logic          running_q;
   logic          frozen_q;
   bcd_time_t     lapTime_q;
   bcd_time_t     liveTime_q;
   bcd_time_t     liveTime_d;
   bcd_time_t     dispBcd_q;
   logic [PW-1:0] preCount_q;
   logic          wrap_q;

   logic          counting;
   logic          tick;
   logic          clrAccept;

   // The debounced levels are not needed here; only the press edges act.
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebSs (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_ss),
      .level (unusedLevel[0]),
      .press (pressSs)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebLap (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_lap),
      .level (unusedLevel[1]),
      .press (pressLap)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uDebClr (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_clr),
      .level (unusedLevel[2]),
      .press (pressClr)
   );

   // Time advances in RUN and LAP; clear only has effect when stopped.
   assign counting  = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign tick      = counting && (preCount_q == PRE_LAST);
   assign clrAccept = pressClr && ((state_q == ST_IDLE) || (state_q == ST_PAUSE));

   // State machine with registered status outputs; clear beats start/stop,
   // which beats lap, and lower-priority presses in the same cycle are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         frozen_q  <= 1'b0;
         lapTime_q <= TIME_ZERO;
      end else if (clrAccept) begin
         state_q   <= ST_IDLE;
         running_q <= 1'b0;
         frozen_q  <= 1'b0;
         lapTime_q <= TIME_ZERO;
      end else if (pressSs) begin
         case (state_q)
            ST_IDLE, ST_PAUSE: begin
               state_q   <= ST_RUN;
               running_q <= 1'b1;
               frozen_q  <= 1'b0;
            end
            ST_RUN, ST_LAP: begin
               state_q   <= ST_PAUSE;
               running_q <= 1'b0;
               frozen_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end else if (pressLap) begin
         case (state_q)
            ST_RUN: begin
               state_q   <= ST_LAP;
               frozen_q  <= 1'b1;
               lapTime_q <= liveTime_q;
            end
            ST_LAP: begin
               state_q  <= ST_RUN;
               frozen_q <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Prescaler: runs while counting, holds in PAUSE to keep the fraction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preCount_q <= '0;
      end else if (clrAccept) begin
         preCount_q <= '0;
      end else if (counting) begin
         preCount_q <= tick ? '0 : preCount_q + PW'(1);
      end
   end

   // Next live time: one second further on each tick.
   always_comb begin
      liveTime_d = liveTime_q;
      if (tick) begin
         liveTime_d = bcdIncrement(liveTime_q);
      end
   end

   // Live BCD counter and the one-cycle rollover flag that accompanies it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         liveTime_q <= TIME_ZERO;
         wrap_q     <= 1'b0;
      end else if (clrAccept) begin
         liveTime_q <= TIME_ZERO;
         wrap_q     <= 1'b0;
      end else begin
         liveTime_q <= liveTime_d;
         wrap_q     <= tick && bcdIsMax(liveTime_q);
      end
   end

   // Display register: frozen lap value while in LAP, live time otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dispBcd_q <= TIME_ZERO;
      end else begin
         dispBcd_q <= (state_q == ST_LAP) ? lapTime_q : liveTime_q;
      end
   end

   assign disp_bcd[MIN_TENS_LSB +: DIGIT_W] = dispBcd_q.minTens;
   assign disp_bcd[MIN_ONES_LSB +: DIGIT_W] = dispBcd_q.minOnes;
   assign disp_bcd[SEC_TENS_LSB +: DIGIT_W] = dispBcd_q.secTens;
   assign disp_bcd[SEC_ONES_LSB +: DIGIT_W] = dispBcd_q.secOnes;

   assign running = running_q;
   assign frozen  = frozen_q;
   assign state   = state_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a seconds-level reference model pushes
// the expected outputs every clock, a negedge monitor pops and compares.
module tb_stopwatch_ctrl;

   localparam int FREQ = 4;
   localparam int DEB  = 3;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  btnRaw = 3'b000;   // [0]=start/stop [1]=lap [2]=clear
   logic [15:0] disp_bcd;
   logic        running;
   logic        frozen;
   logic [1:0]  state;
   logic        wrap;

   int errors = 0;
   int checks = 0;
   int wrapCount = 0;

   typedef struct {
      logic [15:0] disp;
      logic [4:0]  ctrl;
   } exp_t;

   exp_t expQ[$];

   // Reference model state: mode 0..3, fraction of a second, total seconds.
   int           mode = 0;
   int           frac = 0;
   int           secs = 0;
   int           lapSecs = 0;
   bit           pend [3];
   bit           lvl  [3];
   bit           d1   [3];
   bit           d2   [3];
   logic [DEB-1:0] win [3];

   always #5 clk = ~clk;

   stopwatch_ctrl #(.FREQ(FREQ), .DEB_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_ss   (btnRaw[0]),
      .btn_lap  (btnRaw[1]),
      .btn_clr  (btnRaw[2]),
      .disp_bcd (disp_bcd),
      .running  (running),
      .frozen   (frozen),
      .state    (state),
      .wrap     (wrap)
   );

   function automatic logic [15:0] bcdOf(input int s);
      int m;
      int sc;
      m  = s / 60;
      sc = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
   endfunction

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   // Reference model: one step per clock, pushes what the DUT should show next.
   always @(posedge clk or negedge rst_n) begin
      logic [15:0] oldDisp;
      bit          isCounting;
      bit          tick;
      bit          w;
      bit          clrOk;
      bit          cmp;
      int          nmode;
      if (!rst_n) begin
         mode = 0; frac = 0; secs = 0; lapSecs = 0;
         for (int b = 0; b < 3; b++) begin
            pend[b] = 0; lvl[b] = 0; d1[b] = 0; d2[b] = 0; win[b] = '0;
         end
         expQ.delete();
         expQ.push_back('{16'h0000, 5'b00000});
      end else begin
         oldDisp    = (mode == 3) ? bcdOf(lapSecs) : bcdOf(secs);
         isCounting = (mode == 1) || (mode == 3);
         tick       = isCounting && (frac == FREQ - 1);
         w          = 0;
         clrOk      = pend[2] && ((mode == 0) || (mode == 2));
         nmode      = mode;
         if (clrOk) begin
            secs = 0; frac = 0; lapSecs = 0; nmode = 0;
         end else begin
            if (pend[0]) begin
               case (mode)
                  0, 2: nmode = 1;
                  default: nmode = 2;
               endcase
            end else if (pend[1]) begin
               if (mode == 1) begin
                  nmode   = 3;
                  lapSecs = secs;
               end else if (mode == 3) begin
                  nmode = 1;
               end
            end
            if (isCounting) frac = (frac + 1) % FREQ;
            if (tick) begin
               w    = (secs == 3599);
               secs = (secs + 1) % 3600;
            end
         end
         mode = nmode;
         for (int b = 0; b < 3; b++) begin
            cmp     = d2[b];
            d2[b]   = d1[b];
            d1[b]   = btnRaw[b];
            win[b]  = {win[b][DEB-2:0], cmp};
            pend[b] = 0;
            if (win[b] == {DEB{~lvl[b]}}) begin
               lvl[b]  = ~lvl[b];
               pend[b] = lvl[b];
            end
         end
         expQ.push_back('{oldDisp, {2'(mode), (mode == 1) || (mode == 3), mode == 3, w}});
      end
   end

   // Monitor: compare every cycle away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (wrap === 1'b1) wrapCount++;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard at %0t: got no expectation, expected one queued", $time);
      end else begin
         e = expQ.pop_front();
         checkOutput("disp", disp_bcd, e.disp);
         checkOutput("ctrl", {11'd0, state, running, frozen, wrap}, {11'd0, e.ctrl});
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Press a set of buttons, optionally preceded by sub-threshold bounce.
   task automatic applyStimulus(input logic [2:0] mask, input bit bounce);
      if (bounce) begin
         repeat ($urandom_range(1, 3)) begin
            btnRaw = btnRaw | mask;
            waitCycles($urandom_range(1, DEB - 1));
            btnRaw = btnRaw & ~mask;
            waitCycles($urandom_range(1, DEB - 1));
         end
      end
      btnRaw = btnRaw | mask;
      waitCycles($urandom_range(DEB + 1, DEB + 6));
      btnRaw = btnRaw & ~mask;
      waitCycles(DEB + 4);
   endtask

   initial begin
      int n;
      waitCycles(3);
      rst_n = 1'b1;
      waitCycles(20);

      // Glitch shorter than the debounce window must be ignored.
      btnRaw[0] = 1'b1;
      waitCycles(DEB - 1);
      btnRaw[0] = 1'b0;
      waitCycles(20);
      checkOutput("glitchIgnored", {14'd0, state}, 16'd0);

      // Clean start/stop press: RUN appears 2 + DEB + 1 cycles after the edge.
      btnRaw[0] = 1'b1;
      n = 0;
      while (state !== 2'd1 && n < 20) begin
         waitCycles(1);
         n++;
      end
      checkOutput("ssLatency", 16'(n), 16'(2 + DEB + 1));
      waitCycles(4);
      btnRaw[0] = 1'b0;
      waitCycles(40);
      applyStimulus(3'b001, 1'b1);
      checkOutput("pauseAfterSs", {14'd0, state}, 16'd2);
      waitCycles(20);

      // Full hour: clear, run past 59:59 and expect a single wrap pulse.
      applyStimulus(3'b100, 1'b0);
      checkOutput("idleAfterClr", {14'd0, state}, 16'd0);
      wrapCount = 0;
      applyStimulus(3'b001, 1'b0);
      waitCycles(3600 * FREQ);
      applyStimulus(3'b001, 1'b0);
      checkOutput("wrapPulses", 16'(wrapCount), 16'd1);

      // Lap freeze and release.
      applyStimulus(3'b100, 1'b0);
      applyStimulus(3'b001, 1'b0);
      waitCycles(3 * FREQ);
      applyStimulus(3'b010, 1'b1);
      checkOutput("frozenInLap", {15'd0, frozen}, 16'd1);
      waitCycles(3 * FREQ);
      applyStimulus(3'b010, 1'b0);
      checkOutput("liveAfterLap", {15'd0, frozen}, 16'd0);

      // Clear ignored while running, honoured when paused.
      applyStimulus(3'b100, 1'b0);
      checkOutput("clrIgnoredRun", {14'd0, state}, 16'd1);
      applyStimulus(3'b001, 1'b0);
      applyStimulus(3'b100, 1'b0);
      checkOutput("clrFromPause", disp_bcd, 16'h0000);

      // All three together in PAUSE: clear wins.
      applyStimulus(3'b001, 1'b0);
      waitCycles(2 * FREQ);
      applyStimulus(3'b001, 1'b0);
      applyStimulus(3'b111, 1'b0);
      checkOutput("allThreeIdle", {14'd0, state}, 16'd0);

      // Run to about 12:34, then assert reset between clock edges.
      applyStimulus(3'b001, 1'b0);
      waitCycles(754 * FREQ);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncDisp", disp_bcd, 16'h0000);
      checkOutput("asyncCtrl", {11'd0, state, running, frozen, wrap}, 16'd0);
      waitCycles(3);
      rst_n = 1'b1;
      waitCycles(20);
      checkOutput("idleAfterReset", {14'd0, state}, 16'd0);

      // Random button traffic checked by the scoreboard.
      repeat (80) begin
         logic [2:0] mask;
         if ($urandom_range(0, 4) == 0) mask = 3'($urandom_range(1, 7));
         else mask = 3'b001 << $urandom_range(0, 2);
         applyStimulus(mask, 1'($urandom_range(0, 1)));
         waitCycles($urandom_range(0, 30));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
